// File: rtl/ps2_scan_decoder.sv
// rtl/ps2_scan_decoder.sv - PS/2 scan-code set 2 receiver with make/break tracking and ASCII translation
// Pins are synchronized and glitch filtered; frames decode to scan_code/ascii_code/key_pressed/key_released.
module ps2_scan_decoder #(
   parameter int FILTER_CYCLES  = 8,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       ps2_clk_async,
   input  logic       ps2_data_async,
   output logic [7:0] scan_code,
   output logic [7:0] ascii_code,
   output logic       key_pressed,
   output logic       key_released
);

   localparam int FW = $clog2(FILTER_CYCLES + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic          clk_meta_q, clk_sync_q, data_meta_q, data_sync_q;
   logic          filt_q, filt_d, filt_prev_q;
   logic [FW-1:0] filt_cnt_q, filt_cnt_d;
   logic [3:0]    bit_cnt_q, bit_cnt_d;
   logic [9:0]    sh_q, sh_d;
   logic [TW-1:0] idle_q, idle_d;
   logic          byte_vld_q, byte_vld_d;
   logic [7:0]    byte_q, byte_d;
   logic          ext_q, ext_d, brk_q, brk_d;
   logic          lshift_q, lshift_d, rshift_q, rshift_d;
   logic [7:0]    scan_q, scan_d, ascii_q, ascii_d;
   logic          pressed_q, pressed_d, rel_q, rel_d;
   logic          fall;

   function automatic logic [7:0] to_ascii(input logic [7:0] code, input logic shift);
      logic [7:0] u;
      logic [7:0] s;
      u = 8'h00;
      case (code)
         8'h1C: u = "a";  8'h32: u = "b";  8'h21: u = "c";  8'h23: u = "d";
         8'h24: u = "e";  8'h2B: u = "f";  8'h34: u = "g";  8'h33: u = "h";
         8'h43: u = "i";  8'h3B: u = "j";  8'h42: u = "k";  8'h4B: u = "l";
         8'h3A: u = "m";  8'h31: u = "n";  8'h44: u = "o";  8'h4D: u = "p";
         8'h15: u = "q";  8'h2D: u = "r";  8'h1B: u = "s";  8'h2C: u = "t";
         8'h3C: u = "u";  8'h2A: u = "v";  8'h1D: u = "w";  8'h22: u = "x";
         8'h35: u = "y";  8'h1A: u = "z";
         8'h45: u = "0";  8'h16: u = "1";  8'h1E: u = "2";  8'h26: u = "3";
         8'h25: u = "4";  8'h2E: u = "5";  8'h36: u = "6";  8'h3D: u = "7";
         8'h3E: u = "8";  8'h46: u = "9";
         8'h4E: u = "-";  8'h55: u = "=";  8'h54: u = "[";  8'h5B: u = "]";
         8'h5D: u = 8'h5C; 8'h4C: u = ";"; 8'h52: u = 8'h27; 8'h41: u = ",";
         8'h49: u = ".";  8'h4A: u = "/";  8'h0E: u = 8'h60;
         8'h29: u = 8'h20; 8'h5A: u = 8'h0D; 8'h66: u = 8'h08;
         8'h0D: u = 8'h09; 8'h76: u = 8'h1B;
         default: u = 8'h00;
      endcase
      // Shifted forms are derived from the unshifted character, not the scan code.
      s = u;
      if (u >= "a" && u <= "z") s = u - 8'h20;
      else begin
         case (u)
            "0": s = ")";  "1": s = "!";  "2": s = "@";  "3": s = "#";
            "4": s = "$";  "5": s = "%";  "6": s = "^";  "7": s = "&";
            "8": s = "*";  "9": s = "(";  "-": s = "_";  "=": s = "+";
            "[": s = "{";  "]": s = "}";  8'h5C: s = "|"; ";": s = ":";
            8'h27: s = 8'h22; ",": s = "<"; ".": s = ">"; "/": s = "?";
            8'h60: s = "~";
            default: s = u;
         endcase
      end
      return shift ? s : u;
   endfunction

   assign fall = filt_prev_q & ~filt_q;

   always_comb begin
      filt_d     = filt_q;
      filt_cnt_d = '0;
      if (clk_sync_q != filt_q) begin
         if (filt_cnt_q == FW'(FILTER_CYCLES - 1)) filt_d = clk_sync_q;
         else                                      filt_cnt_d = filt_cnt_q + 1'b1;
      end
   end

   // sh_q collects start, data and parity LSB-first; the stop bit is checked live.
   always_comb begin
      bit_cnt_d  = bit_cnt_q;
      sh_d       = sh_q;
      idle_d     = '0;
      byte_vld_d = 1'b0;
      byte_d     = byte_q;
      if (fall) begin
         if (bit_cnt_q == 4'd10) begin
            bit_cnt_d = 4'd0;
            if (!sh_q[0] && (^sh_q[9:1]) && data_sync_q) begin
               byte_vld_d = 1'b1;
               byte_d     = sh_q[8:1];
            end
         end else begin
            sh_d      = {data_sync_q, sh_q[9:1]};
            bit_cnt_d = bit_cnt_q + 4'd1;
         end
      end else if (bit_cnt_q != 4'd0) begin
         if (idle_q == TW'(TIMEOUT_CYCLES - 1)) bit_cnt_d = 4'd0;
         else                                   idle_d = idle_q + 1'b1;
      end
   end

   always_comb begin
      ext_d     = ext_q;
      brk_d     = brk_q;
      lshift_d  = lshift_q;
      rshift_d  = rshift_q;
      scan_d    = scan_q;
      ascii_d   = ascii_q;
      pressed_d = pressed_q;
      rel_d     = 1'b0;
      if (byte_vld_q) begin
         if (byte_q == 8'hE0) ext_d = 1'b1;
         else if (byte_q == 8'hF0) brk_d = 1'b1;
         else begin
            ext_d = 1'b0;
            brk_d = 1'b0;
            if (byte_q == 8'h12)      lshift_d = ~brk_q;
            else if (byte_q == 8'h59) rshift_d = ~brk_q;
            else if (brk_q) begin
               rel_d = 1'b1;
               if (byte_q == scan_q) pressed_d = 1'b0;
            end else begin
               scan_d    = byte_q;
               ascii_d   = ext_q ? 8'h00 : to_ascii(byte_q, lshift_q | rshift_q);
               pressed_d = 1'b1;
            end
         end
      end
   end

   // Pin-side registers reset to the idle-high line level so reset never fakes an edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         clk_meta_q  <= 1'b1;
         clk_sync_q  <= 1'b1;
         data_meta_q <= 1'b1;
         data_sync_q <= 1'b1;
         filt_q      <= 1'b1;
         filt_prev_q <= 1'b1;
         filt_cnt_q  <= '0;
         bit_cnt_q   <= 4'd0;
         sh_q        <= '0;
         idle_q      <= '0;
         byte_vld_q  <= 1'b0;
         byte_q      <= 8'h00;
         ext_q       <= 1'b0;
         brk_q       <= 1'b0;
         lshift_q    <= 1'b0;
         rshift_q    <= 1'b0;
         scan_q      <= 8'h00;
         ascii_q     <= 8'h00;
         pressed_q   <= 1'b0;
         rel_q       <= 1'b0;
      end else begin
         clk_meta_q  <= ps2_clk_async;
         clk_sync_q  <= clk_meta_q;
         data_meta_q <= ps2_data_async;
         data_sync_q <= data_meta_q;
         filt_q      <= filt_d;
         filt_prev_q <= filt_q;
         filt_cnt_q  <= filt_cnt_d;
         bit_cnt_q   <= bit_cnt_d;
         sh_q        <= sh_d;
         idle_q      <= idle_d;
         byte_vld_q  <= byte_vld_d;
         byte_q      <= byte_d;
         ext_q       <= ext_d;
         brk_q       <= brk_d;
         lshift_q    <= lshift_d;
         rshift_q    <= rshift_d;
         scan_q      <= scan_d;
         ascii_q     <= ascii_d;
         pressed_q   <= pressed_d;
         rel_q       <= rel_d;
      end
   end

   assign scan_code    = scan_q;
   assign ascii_code   = ascii_q;
   assign key_pressed  = pressed_q;
   assign key_released = rel_q;

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// tb/tb_ps2_scan_decoder.sv - scoreboard bench for ps2_scan_decoder
module tb_ps2_scan_decoder;

   localparam int HALF = 20;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic [7:0] scan_code, ascii_code;
   logic       key_pressed, key_released;

   typedef logic [17:0] obs_t;
   obs_t sb[$];
   int   n_cmp = 0;
   int   n_err = 0;

   int   rel_pulses = 0, rel_last_w = 0, rel_run = 0, press_drops = 0;
   logic pressed_prev = 1'b0;
   logic seen_12 = 1'b0;

   always #10 clk = ~clk;

   ps2_scan_decoder dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .ps2_clk_async  (ps2_clk),
      .ps2_data_async (ps2_data),
      .scan_code      (scan_code),
      .ascii_code     (ascii_code),
      .key_pressed    (key_pressed),
      .key_released   (key_released)
   );

   always @(negedge clk) begin
      if (key_released) rel_run <= rel_run + 1;
      else if (rel_run != 0) begin
         rel_pulses <= rel_pulses + 1;
         rel_last_w <= rel_run;
         rel_run    <= 0;
      end
      if (pressed_prev && !key_pressed && reset_n) press_drops <= press_drops + 1;
      pressed_prev <= key_pressed;
      if (scan_code == 8'h12) seen_12 <= 1'b1;
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_bits(input logic [7:0] b, input logic bad_par, input int nbits);
      logic [10:0] fr;
      fr = {1'b1, (~^b) ^ bad_par, b, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         ps2_data = fr[i];
         wait_cyc(HALF);
         ps2_clk = 1'b0;
         wait_cyc(HALF);
         ps2_clk = 1'b1;
      end
      wait_cyc(HALF);
      ps2_data = 1'b1;
      wait_cyc(2 * HALF);
   endtask

   task automatic test_reset();
      obs_t e, g;
      sb.push_back({8'h00, 8'h00, 1'b0, 1'b0});
      wait_cyc(5);
      e = sb.pop_front();
      g = {scan_code, ascii_code, key_pressed, key_released};
      n_cmp++;
      if (g !== e) begin n_err++; $display("FAIL reset: got %h want %h", g, e); end
   endtask

   task automatic test_make();
      obs_t e, g;
      sb.push_back({8'h1C, 8'h61, 1'b1, 1'b0});
      send_bits(8'h1C, 1'b0, 11);
      e = sb.pop_front();
      g = {scan_code, ascii_code, key_pressed, key_released};
      n_cmp++;
      if (g !== e) begin n_err++; $display("FAIL make_1c: got %h want %h", g, e); end
   endtask

   task automatic test_break();
      obs_t e, g;
      int r0;
      r0 = rel_pulses;
      sb.push_back({8'h1C, 8'h61, 1'b1, 1'b0});
      send_bits(8'hF0, 1'b0, 11);
      e = sb.pop_front();
      g = {scan_code, ascii_code, key_pressed, key_released};
      n_cmp++;
      if (g !== e) begin n_err++; $display("FAIL break_prefix: got %h want %h", g, e); end
      sb.push_back({8'h1C, 8'h61, 1'b0, 1'b0});
      send_bits(8'h1C, 1'b0, 11);
      e = sb.pop_front();
      g = {scan_code, ascii_code, key_pressed, key_released};
      n_cmp++;
      if (g !== e) begin n_err++; $display("FAIL break_1c: got %h want %h", g, e); end
      n_cmp++;
      if (rel_pulses - r0 !== 1) begin
         n_err++; $display("FAIL release_count: got %0d want 1", rel_pulses - r0);
      end
      n_cmp++;
      if (rel_last_w !== 1) begin
         n_err++; $display("FAIL release_width: got %0d want 1", rel_last_w);
      end
   endtask

   task automatic test_shift();
      logic [7:0] seq [7];
      obs_t       exp_tab [7];
      obs_t       e, g;
      seq = '{8'h12, 8'h1C, 8'hF0, 8'h1C, 8'hF0, 8'h12, 8'h1C};
      exp_tab = '{{8'h1C, 8'h61, 1'b0, 1'b0}, {8'h1C, 8'h41, 1'b1, 1'b0},
                  {8'h1C, 8'h41, 1'b1, 1'b0}, {8'h1C, 8'h41, 1'b0, 1'b0},
                  {8'h1C, 8'h41, 1'b0, 1'b0}, {8'h1C, 8'h41, 1'b0, 1'b0},
                  {8'h1C, 8'h61, 1'b1, 1'b0}};
      for (int i = 0; i < 7; i++) begin
         sb.push_back(exp_tab[i]);
         send_bits(seq[i], 1'b0, 11);
         e = sb.pop_front();
         g = {scan_code, ascii_code, key_pressed, key_released};
         n_cmp++;
         if (g !== e) begin n_err++; $display("FAIL shift_step%0d: got %h want %h", i, g, e); end
      end
      n_cmp++;
      if (seen_12 !== 1'b0) begin n_err++; $display("FAIL shift_scan12: got %b want 0", seen_12); end
   endtask

   task automatic test_parity();
      obs_t e, g;
      sb.push_back({8'h1C, 8'h61, 1'b1, 1'b0});
      send_bits(8'h29, 1'b1, 11);
      e = sb.pop_front();
      g = {scan_code, ascii_code, key_pressed, key_released};
      n_cmp++;
      if (g !== e) begin n_err++; $display("FAIL bad_parity: got %h want %h", g, e); end
      sb.push_back({8'h29, 8'h20, 1'b1, 1'b0});
      send_bits(8'h29, 1'b0, 11);
      e = sb.pop_front();
      g = {scan_code, ascii_code, key_pressed, key_released};
      n_cmp++;
      if (g !== e) begin n_err++; $display("FAIL space: got %h want %h", g, e); end
   endtask

   task automatic test_timeout();
      obs_t e, g;
      send_bits(8'h55, 1'b0, 4);
      wait_cyc(60000);
      sb.push_back({8'h16, 8'h31, 1'b1, 1'b0});
      send_bits(8'h16, 1'b0, 11);
      e = sb.pop_front();
      g = {scan_code, ascii_code, key_pressed, key_released};
      n_cmp++;
      if (g !== e) begin n_err++; $display("FAIL timeout_16: got %h want %h", g, e); end
   endtask

   task automatic test_back_to_back();
      obs_t e, g;
      int d0;
      d0 = press_drops;
      for (int i = 0; i < 3; i++) begin
         sb.push_back({8'h1C, 8'h61, 1'b1, 1'b0});
         send_bits(8'h1C, 1'b0, 11);
         e = sb.pop_front();
         g = {scan_code, ascii_code, key_pressed, key_released};
         n_cmp++;
         if (g !== e) begin n_err++; $display("FAIL typematic%0d: got %h want %h", i, g, e); end
      end
      n_cmp++;
      if (press_drops - d0 !== 0) begin
         n_err++; $display("FAIL typematic_gap: got %0d drops want 0", press_drops - d0);
      end
   endtask

   task automatic test_ext_reset();
      obs_t e, g;
      sb.push_back({8'h1C, 8'h61, 1'b1, 1'b0});
      send_bits(8'hE0, 1'b0, 11);
      e = sb.pop_front();
      g = {scan_code, ascii_code, key_pressed, key_released};
      n_cmp++;
      if (g !== e) begin n_err++; $display("FAIL ext_prefix: got %h want %h", g, e); end
      sb.push_back({8'h75, 8'h00, 1'b1, 1'b0});
      send_bits(8'h75, 1'b0, 11);
      e = sb.pop_front();
      g = {scan_code, ascii_code, key_pressed, key_released};
      n_cmp++;
      if (g !== e) begin n_err++; $display("FAIL ext_75: got %h want %h", g, e); end
      send_bits(8'h33, 1'b0, 4);
      sb.push_back({8'h00, 8'h00, 1'b0, 1'b0});
      #3 reset_n = 1'b0;
      #1;
      e = sb.pop_front();
      g = {scan_code, ascii_code, key_pressed, key_released};
      n_cmp++;
      if (g !== e) begin n_err++; $display("FAIL midframe_reset: got %h want %h", g, e); end
      wait_cyc(5);
      reset_n = 1'b1;
      wait_cyc(5);
      sb.push_back({8'h1C, 8'h61, 1'b1, 1'b0});
      send_bits(8'h1C, 1'b0, 11);
      e = sb.pop_front();
      g = {scan_code, ascii_code, key_pressed, key_released};
      n_cmp++;
      if (g !== e) begin n_err++; $display("FAIL after_reset: got %h want %h", g, e); end
   endtask

   initial begin
      test_reset();
      reset_n = 1'b1;
      wait_cyc(5);
      test_make();
      test_break();
      test_shift();
      test_parity();
      test_timeout();
      test_back_to_back();
      test_ext_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
